// File: rtl/video_scan_pkg.sv
// Shared geometry presets, counter bundle and helpers for the video_scan raster generator.
package video_scan_pkg;

    localparam int CHAR_PX = 8;
    localparam int CNT_W   = 16;

    // 40-column PET geometry
    localparam int G40_H_TOTAL      = 64;
    localparam int G40_H_VISIBLE    = 40;
    localparam int G40_H_SYNC_START = 48;
    localparam int G40_H_SYNC_LEN   = 4;
    localparam int G40_V_TOTAL      = 260;
    localparam int G40_V_ROWS       = 25;
    localparam int G40_CHAR_LINES   = 8;
    localparam int G40_V_SYNC_START = 224;
    localparam int G40_V_SYNC_LEN   = 8;

    // 80-column PET geometry
    localparam int G80_H_TOTAL      = 128;
    localparam int G80_H_VISIBLE    = 80;
    localparam int G80_H_SYNC_START = 96;
    localparam int G80_H_SYNC_LEN   = 8;
    localparam int G80_V_TOTAL      = 260;
    localparam int G80_V_ROWS       = 25;
    localparam int G80_CHAR_LINES   = 8;
    localparam int G80_V_SYNC_START = 224;
    localparam int G80_V_SYNC_LEN   = 8;

    typedef struct packed {
        logic [2:0]       px;
        logic [CNT_W-1:0] hc;
        logic [2:0]       ra;
        logic [CNT_W-1:0] vc;
    } scan_cnt_t;

    function automatic logic in_span(input logic [CNT_W-1:0] pos, input int start, input int len);
        return (int'(pos) >= start) && (int'(pos) < start + len);
    endfunction

endpackage

// File: rtl/video_shifter.sv
// 8-bit parallel-load shift register; shifts MSB-first, load takes priority over shift.
module video_shifter (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] data_i,
    output logic       msb_o
);

    logic [7:0] shreg_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shreg_q <= 8'h00;
        end else if (load_i) begin
            shreg_q <= data_i;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[6:0], 1'b0};
        end
    end

    assign msb_o = shreg_q[7];

endmodule

// File: rtl/video_scan.sv
// Parametrised PET character raster generator: counters, VRAM/char-ROM fetch, pixel shifter, syncs.
// Build option VIDEO_SCAN_INVERT_EN: code[7] selects reverse video instead of ROM address bit 10.
module video_scan
    import video_scan_pkg::*;
#(
    parameter int H_TOTAL      = 64,
    parameter int H_VISIBLE    = 40,
    parameter int H_SYNC_START = 48,
    parameter int H_SYNC_LEN   = 4,
    parameter int V_TOTAL      = 260,
    parameter int V_ROWS       = 25,
    parameter int CHAR_LINES   = 8,
    parameter int V_SYNC_START = 224,
    parameter int V_SYNC_LEN   = 8,
    parameter int VRAM_AW      = 11
) (
    input  logic               clk16_i,
    input  logic               reset_i,
    input  logic               pixel_en_i,
    input  logic               vram_en_i,
    input  logic               vrom_en_i,
    input  logic [VRAM_AW-1:0] start_addr_i,
    input  logic               gfx_i,
    input  logic [7:0]         data_i,
    output logic [VRAM_AW-1:0] vram_addr_o,
    output logic [10:0]        vrom_addr_o,
    output logic               h_sync_o,
    output logic               v_sync_o,
    output logic               de_o,
    output logic               video_o
);

    localparam int V_VIS_LINES = V_ROWS * CHAR_LINES;

    scan_cnt_t          cnt_q, cnt_d;
    logic [VRAM_AW-1:0] row_base_q, row_base_d;
    logic [VRAM_AW-1:0] vram_addr_q;
    logic [7:0]         code_q, pattern_q;
    logic               rom_seen_q;
    logic               de_q, h_sync_q, v_sync_q;

    logic px_last, hc_last, ra_last, vc_last, line_end;
    logic fetch_open, vram_hit, rom_hit, seen_cur;
    logic [7:0] pattern_cur, glyph, load_val;
    logic rom_msb;

    assign px_last  = pixel_en_i && (cnt_q.px == 3'd7);
    assign hc_last  = cnt_q.hc == CNT_W'(H_TOTAL - 1);
    assign ra_last  = cnt_q.ra == 3'(CHAR_LINES - 1);
    assign vc_last  = cnt_q.vc == CNT_W'(V_TOTAL - 1);
    assign line_end = px_last && hc_last;

    always_comb begin
        cnt_d = cnt_q;
        if (pixel_en_i) begin
            cnt_d.px = cnt_q.px + 3'd1;
        end
        if (px_last) begin
            cnt_d.hc = hc_last ? '0 : cnt_q.hc + CNT_W'(1);
        end
        if (line_end) begin
            cnt_d.ra = (ra_last || vc_last) ? '0 : cnt_q.ra + 3'd1;
            cnt_d.vc = vc_last ? '0 : cnt_q.vc + CNT_W'(1);
        end
    end

    // Frame reload wins over the per-row advance when both fall on the same line end.
    always_comb begin
        row_base_d = row_base_q;
        if (line_end) begin
            if (vc_last) begin
                row_base_d = start_addr_i;
            end else if (ra_last && (cnt_q.vc < CNT_W'(V_VIS_LINES))) begin
                row_base_d = row_base_q + VRAM_AW'(H_VISIBLE);
            end
        end
    end

    assign fetch_open = (cnt_q.hc < CNT_W'(H_VISIBLE)) && (cnt_q.vc < CNT_W'(V_VIS_LINES));
    assign vram_hit   = fetch_open && vram_en_i;
    assign rom_hit    = fetch_open && vrom_en_i && !vram_en_i;

    // A ROM strobe on the last pixel of the cell still reaches this cell's load.
    assign pattern_cur = rom_hit ? data_i : pattern_q;
    assign seen_cur    = rom_seen_q || rom_hit;

`ifdef VIDEO_SCAN_INVERT_EN
    assign glyph   = code_q[7] ? ~pattern_cur : pattern_cur;
    assign rom_msb = gfx_i;
`else
    logic unused_gfx;
    assign unused_gfx = gfx_i;
    assign glyph      = pattern_cur;
    assign rom_msb    = code_q[7];
`endif

    assign load_val = (fetch_open && seen_cur) ? glyph : 8'h00;

    always_ff @(posedge clk16_i) begin
        if (reset_i) begin
            cnt_q       <= '0;
            row_base_q  <= '0;
            vram_addr_q <= '0;
            code_q      <= 8'h00;
            pattern_q   <= 8'h00;
            rom_seen_q  <= 1'b0;
            de_q        <= 1'b0;
            h_sync_q    <= 1'b0;
            v_sync_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            row_base_q  <= row_base_d;
            vram_addr_q <= row_base_d + VRAM_AW'(cnt_d.hc);
            h_sync_q    <= in_span(cnt_d.hc, H_SYNC_START, H_SYNC_LEN);
            v_sync_q    <= in_span(cnt_d.vc, V_SYNC_START, V_SYNC_LEN);
            if (vram_hit) begin
                code_q <= data_i;
            end
            if (rom_hit) begin
                pattern_q <= data_i;
            end
            rom_seen_q <= px_last ? 1'b0 : seen_cur;
            if (px_last) begin
                de_q <= fetch_open;
            end
        end
    end

    video_shifter u_shifter (
        .clk_i   (clk16_i),
        .reset_i (reset_i),
        .load_i  (px_last),
        .shift_i (pixel_en_i),
        .data_i  (load_val),
        .msb_o   (video_o)
    );

    assign vram_addr_o = vram_addr_q;
    assign vrom_addr_o = {rom_msb, code_q[6:0], cnt_q.ra};
    assign h_sync_o    = h_sync_q;
    assign v_sync_o    = v_sync_q;
    assign de_o        = de_q;

endmodule

// File: tb/tb_video_scan.sv
// Scoreboard bench for video_scan on a small 6x20 geometry with a cycle-level counter model.
module tb_video_scan;

    localparam int HT = 6, HV = 4, HSS = 4, HSL = 1;
    localparam int VT = 20, VR = 2, CL = 8, VSS = 17, VSL = 2, AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b0, pixel_en = 1'b0, vram_en = 1'b0, vrom_en = 1'b0, gfx = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [7:0]    data = 8'h00;
    logic [AW-1:0] vram_addr;
    logic [10:0]   vrom_addr;
    logic          h_sync, v_sync, de, video;

    video_scan #(
        .H_TOTAL(HT), .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ROWS(VR), .CHAR_LINES(CL), .V_SYNC_START(VSS),
        .V_SYNC_LEN(VSL), .VRAM_AW(AW)
    ) dut (
        .clk16_i(clk), .reset_i(reset), .pixel_en_i(pixel_en), .vram_en_i(vram_en),
        .vrom_en_i(vrom_en), .start_addr_i(start_addr), .gfx_i(gfx), .data_i(data),
        .vram_addr_o(vram_addr), .vrom_addr_o(vrom_addr), .h_sync_o(h_sync),
        .v_sync_o(v_sync), .de_o(de), .video_o(video)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pix;
        logic       de;
    } exp_t;

    int        n_tests = 0, n_fail = 0;
    int        m_px = 0, m_hc = 0, m_ra = 0, m_vc = 0;
    logic [7:0] m_code = 8'h00;
    longint    cyc = 0;
    exp_t      exp_q[$];
    exp_t      exp_cur;
    logic [7:0]    obs_pix;
    logic          obs_de;
    logic [AW-1:0] obs_vaddr;
    logic [10:0]   obs_rom_addr;
    int        hs_cnt = 0, vs_cnt = 0;
    logic      vs_prev = 1'b0;
    longint    vs_rise[$];

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_px = 0; m_hc = 0; m_ra = 0; m_vc = 0;
        end else if (pixel_en) begin
            if (m_px == 7) begin
                m_px = 0;
                if (m_hc == HT - 1) begin
                    m_hc = 0;
                    if (m_vc == VT - 1) begin
                        m_vc = 0;
                        m_ra = 0;
                    end else begin
                        m_vc++;
                        m_ra = (m_ra == CL - 1) ? 0 : m_ra + 1;
                    end
                end else begin
                    m_hc++;
                end
            end else begin
                m_px++;
            end
        end
        cyc++;
        #1;
    endtask

    // Drives one full cell; captures the output of the previous cell and queues this cell's expectation.
    task automatic run_cell(input bit do_vram, input logic [7:0] code, input bit do_rom, input logic [7:0] pat);
        bit   open;
        exp_t e;
        open = (m_hc < HV) && (m_vc < VR * CL);
        if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
        else begin
            exp_cur.pix = 8'h00;
            exp_cur.de  = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            obs_pix[7-k] = video;
            if (k == 0) begin
                obs_de    = de;
                obs_vaddr = vram_addr;
            end
            if (h_sync) hs_cnt++;
            if (v_sync) vs_cnt++;
            if (v_sync && !vs_prev) vs_rise.push_back(cyc);
            vs_prev = v_sync;
            vram_en = do_vram && (k == 2);
            vrom_en = do_rom && (k == 5);
            data    = (k == 2) ? code : (k == 5) ? pat : 8'hEE;
            if (k == 7) obs_rom_addr = vrom_addr;
            tick();
        end
        vram_en = 1'b0;
        vrom_en = 1'b0;
        if (open && do_vram) m_code = code;
        e.de  = open;
        e.pix = 8'h00;
        if (open && do_rom) begin
            e.pix = pat;
`ifdef VIDEO_SCAN_INVERT_EN
            if (m_code[7]) e.pix = ~pat;
`endif
        end
        exp_q.push_back(e);
    endtask

    task automatic run_to(input int hc, input int vc);
        int guard;
        guard = 0;
        while (!(m_hc == hc && m_vc == vc) && guard <= VT * HT + 1) begin
            run_cell(1'b0, 8'h00, 1'b0, 8'h00);
            guard++;
        end
        if (guard > VT * HT + 1) begin
            n_tests++; n_fail++;
            $display("FAIL run_to: cell (%0d,%0d) not reached, at (%0d,%0d)", hc, vc, m_hc, m_vc);
        end
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b1;
        for (int i = 0; i < ncyc; i++) tick();
        reset = 1'b0;
        exp_q.delete();
        exp_cur.pix = 8'h00;
        exp_cur.de  = 1'b0;
        exp_q.push_back(exp_cur);
        m_code  = 8'h00;
        vs_prev = 1'b0;
    endtask

    task automatic test_reset();
        start_addr = 11'h123;
        pixel_en   = 1'b1;
        do_reset(2);
        n_tests++; if (h_sync !== 1'b0) begin n_fail++; $display("FAIL reset_hsync: got %b want 0", h_sync); end
        n_tests++; if (v_sync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: got %b want 0", v_sync); end
        n_tests++; if (de !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", de); end
        n_tests++; if (video !== 1'b0) begin n_fail++; $display("FAIL reset_video: got %b want 0", video); end
        n_tests++; if (vram_addr !== 11'h000) begin n_fail++; $display("FAIL reset_vaddr: got %h want 000", vram_addr); end
        n_tests++; if (vrom_addr !== 11'h000) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 000", vrom_addr); end
    endtask

    task automatic test_glyph();
        logic [AW-1:0] want_addr;
        run_cell(1'b1, 8'h33, 1'b1, 8'h33);
        n_tests++; if (obs_vaddr !== 11'h000) begin n_fail++; $display("FAIL glyph_vaddr0: got %h want 000", obs_vaddr); end
        run_cell(1'b1, 8'h42, 1'b1, 8'hA5);
        want_addr = 11'h001;
        n_tests++; if (obs_vaddr !== want_addr) begin n_fail++; $display("FAIL glyph_vaddr1: got %h want %h", obs_vaddr, want_addr); end
        n_tests++; if (obs_pix !== exp_cur.pix) begin n_fail++; $display("FAIL glyph_33_pix: got %h want %h", obs_pix, exp_cur.pix); end
        n_tests++; if (obs_de !== exp_cur.de) begin n_fail++; $display("FAIL glyph_33_de: got %b want %b", obs_de, exp_cur.de); end
        run_cell(1'b0, 8'h00, 1'b0, 8'h00);
        n_tests++; if (obs_pix !== exp_cur.pix) begin n_fail++; $display("FAIL glyph_a5_pix: got %h want %h", obs_pix, exp_cur.pix); end
        n_tests++; if (obs_de !== exp_cur.de) begin n_fail++; $display("FAIL glyph_a5_de: got %b want %b", obs_de, exp_cur.de); end
    endtask

    task automatic test_invert();
        logic [10:0] want_rom;
        gfx = 1'b0;
        run_cell(1'b1, 8'h81, 1'b1, 8'h0F);
`ifdef VIDEO_SCAN_INVERT_EN
        want_rom = {gfx, 7'h01, 3'(m_ra)};
`else
        want_rom = {1'b1, 7'h01, 3'(m_ra)};
`endif
        n_tests++; if (obs_rom_addr !== want_rom) begin n_fail++; $display("FAIL invert_rom_addr: got %h want %h", obs_rom_addr, want_rom); end
        run_cell(1'b0, 8'h00, 1'b0, 8'h00);
        n_tests++; if (obs_pix !== exp_cur.pix) begin n_fail++; $display("FAIL invert_pix: got %h want %h", obs_pix, exp_cur.pix); end
        n_tests++; if (obs_de !== 1'b1) begin n_fail++; $display("FAIL invert_de: got %b want 1", obs_de); end
    endtask

    task automatic test_missing_rom();
        run_to(0, 1);
        run_cell(1'b1, 8'hAA, 1'b0, 8'h00);
        run_cell(1'b1, 8'h11, 1'b1, 8'hFF);
        n_tests++; if (obs_pix !== 8'h00) begin n_fail++; $display("FAIL missing_rom_pix: got %h want 00", obs_pix); end
        n_tests++; if (obs_de !== exp_cur.de) begin n_fail++; $display("FAIL missing_rom_de: got %b want %b", obs_de, exp_cur.de); end
        run_to(4, 1);
        n_tests++; if (obs_pix !== exp_cur.pix) begin n_fail++; $display("FAIL fetched_pix: got %h want %h", obs_pix, exp_cur.pix); end
        run_cell(1'b1, 8'h11, 1'b1, 8'hFF);
        run_cell(1'b0, 8'h00, 1'b0, 8'h00);
        n_tests++; if (obs_pix !== exp_cur.pix) begin n_fail++; $display("FAIL closed_pix: got %h want %h", obs_pix, exp_cur.pix); end
        n_tests++; if (obs_de !== 1'b0) begin n_fail++; $display("FAIL closed_de: got %b want 0", obs_de); end
    endtask

    task automatic test_addr_wrap();
        logic [AW-1:0] want;
        start_addr = 11'h7FE;
        run_to(0, 0);
        for (int h = 0; h < HV; h++) begin
            run_cell(1'b0, 8'h00, 1'b0, 8'h00);
            want = AW'(32'h7FE + h);
            n_tests++; if (obs_vaddr !== want) begin n_fail++; $display("FAIL addr_row0_hc%0d: got %h want %h", h, obs_vaddr, want); end
        end
        run_to(0, CL);
        run_cell(1'b0, 8'h00, 1'b0, 8'h00);
        want = AW'(32'h7FE + HV);
        n_tests++; if (obs_vaddr !== want) begin n_fail++; $display("FAIL addr_row1: got %h want %h", obs_vaddr, want); end
    endtask

    task automatic test_syncs();
        run_to(0, 0);
        hs_cnt = 0; vs_cnt = 0; vs_rise.delete(); vs_prev = v_sync;
        for (int c = 0; c < HT; c++) run_cell(1'b0, 8'h00, 1'b0, 8'h00);
        n_tests++; if (hs_cnt != HSL * 8) begin n_fail++; $display("FAIL hsync_line: got %0d want %0d", hs_cnt, HSL * 8); end
        for (int c = HT; c < VT * HT; c++) run_cell(1'b0, 8'h00, 1'b0, 8'h00);
        n_tests++; if (hs_cnt != VT * HSL * 8) begin n_fail++; $display("FAIL hsync_frame: got %0d want %0d", hs_cnt, VT * HSL * 8); end
        n_tests++; if (vs_cnt != VSL * HT * 8) begin n_fail++; $display("FAIL vsync_len: got %0d want %0d", vs_cnt, VSL * HT * 8); end
        for (int c = 0; c < VT * HT; c++) run_cell(1'b0, 8'h00, 1'b0, 8'h00);
        n_tests++;
        if (vs_rise.size() < 2) begin
            n_fail++; $display("FAIL vsync_period: got %0d rising edges want 2", vs_rise.size());
        end else if (vs_rise[1] - vs_rise[0] != longint'(VT * HT * 8)) begin
            n_fail++; $display("FAIL vsync_period: got %0d want %0d", vs_rise[1] - vs_rise[0], VT * HT * 8);
        end
    endtask

    task automatic test_midframe_reset();
        run_to(HSS, 10);
        n_tests++; if (h_sync !== 1'b1) begin n_fail++; $display("FAIL pre_reset_hsync: got %b want 1", h_sync); end
        do_reset(1);
        n_tests++; if (dut.cnt_q.hc !== 16'd0) begin n_fail++; $display("FAIL midreset_hc: got %0d want 0", dut.cnt_q.hc); end
        n_tests++; if (dut.cnt_q.vc !== 16'd0) begin n_fail++; $display("FAIL midreset_vc: got %0d want 0", dut.cnt_q.vc); end
        n_tests++; if (h_sync !== 1'b0) begin n_fail++; $display("FAIL midreset_hsync: got %b want 0", h_sync); end
        n_tests++; if (v_sync !== 1'b0) begin n_fail++; $display("FAIL midreset_vsync: got %b want 0", v_sync); end
        run_cell(1'b1, 8'h3C, 1'b1, 8'h3C);
        run_cell(1'b0, 8'h00, 1'b0, 8'h00);
        n_tests++; if (obs_pix !== exp_cur.pix) begin n_fail++; $display("FAIL restart_pix: got %h want %h", obs_pix, exp_cur.pix); end
    endtask

    initial begin
        test_reset();
        test_glyph();
        test_invert();
        test_missing_rom();
        test_addr_wrap();
        test_syncs();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
